// File: rtl/axis_gen_pkg.sv
// Shared types and data-sequence helpers for the AXI-Stream burst generator.
// Holds the state and mode enums and the counter/LFSR step functions.
package axis_gen_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    GAP    = 2'd2,
    FINISH = 2'd3
  } state_t;

  typedef enum logic {
    MODE_CNT  = 1'b0,
    MODE_LFSR = 1'b1
  } mode_t;

  // Fibonacci taps 32,22,2,1 expressed as bit positions 31,21,1,0
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  function automatic logic [31:0] next_data(mode_t m, logic [31:0] s);
    if (m == MODE_LFSR) begin
      next_data = {s[30:0], ^(s & LFSR_TAPS)};
    end else begin
      next_data = s + 32'd1;
    end
  endfunction

  // An all-zero LFSR state never leaves zero, so that seed is forced to 1.
  function automatic logic [31:0] seed_value(mode_t m, logic [31:0] seed);
    if ((m == MODE_LFSR) && (seed == 32'd0)) begin
      seed_value = 32'd1;
    end else begin
      seed_value = seed;
    end
  endfunction

endpackage

// File: rtl/axis_burst_datagen.sv
// Data sequence register for the burst generator: loads a seed, steps on each
// accepted beat and presents the 32-bit state replicated across tdata.
module axis_burst_datagen
  import axis_gen_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      load_i,
  input  logic                      advance_i,
  input  logic                      mode_i,
  input  logic [31:0]               seed_i,
  output logic [AXI_DATA_WIDTH-1:0] tdata_o
);

  localparam int REPS = AXI_DATA_WIDTH / 32;

  mode_t       mode_q, mode_d;
  logic [31:0] s_q, s_d;

  always_comb begin
    mode_d = mode_q;
    s_d    = s_q;
    if (load_i) begin
      mode_d = mode_t'(mode_i);
      s_d    = seed_value(mode_t'(mode_i), seed_i);
    end else if (advance_i) begin
      s_d = next_data(mode_q, s_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q <= MODE_CNT;
      s_q    <= '0;
    end else begin
      mode_q <= mode_d;
      s_q    <= s_d;
    end
  end

  assign tdata_o = {REPS{s_q}};

endmodule

// File: rtl/axis_burst_gen.sv
// AXI-Stream burst source: emits burst_len beats of counter or LFSR data with
// an optional fixed idle gap after each accepted beat, then pulses done.
module axis_burst_gen
  import axis_gen_pkg::*;
#(
  parameter int AXI_DATA_WIDTH  = 32,
  parameter int BURST_LEN_WIDTH = 16,
  parameter int GAP_WIDTH       = 8
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic                       start,
  input  logic                       mode,
  input  logic [31:0]                seed,
  input  logic [BURST_LEN_WIDTH-1:0] burst_len,
  input  logic [GAP_WIDTH-1:0]       gap,
  output logic                       busy,
  output logic                       done,
  output logic [BURST_LEN_WIDTH-1:0] words_sent,
  output logic [AXI_DATA_WIDTH-1:0]  m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready
);

  // Handshake: a beat transfers on a rising edge where tvalid and tready are
  // both high. tvalid is a flop driven only from the next state, never from
  // tready, and tvalid/tdata hold until that transfer happens.

  localparam logic [BURST_LEN_WIDTH-1:0] LEN_ONE = BURST_LEN_WIDTH'(1);
  localparam logic [GAP_WIDTH-1:0]       GAP_ONE = GAP_WIDTH'(1);

  state_t                     state_q, state_d;
  logic [BURST_LEN_WIDTH-1:0] len_q, len_d;
  logic [GAP_WIDTH-1:0]       gap_q, gap_d;
  logic [GAP_WIDTH-1:0]       gcnt_q, gcnt_d;
  logic [BURST_LEN_WIDTH-1:0] ws_q, ws_d;
  logic                       tvalid_q, busy_q, done_q;
  logic                       beat;
  logic                       dg_load, dg_adv;
  logic [BURST_LEN_WIDTH-1:0] ws_inc;

  assign beat   = tvalid_q & m_axis_tready;
  assign ws_inc = ws_q + LEN_ONE;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    gap_d   = gap_q;
    gcnt_d  = gcnt_q;
    ws_d    = ws_q;
    dg_load = 1'b0;
    dg_adv  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = burst_len;
          gap_d   = gap;
          ws_d    = '0;
          dg_load = 1'b1;
          state_d = (burst_len == '0) ? FINISH : SEND;
        end
      end
      SEND: begin
        if (beat) begin
          ws_d   = ws_inc;
          dg_adv = 1'b1;
          if (ws_inc == len_q) begin
            state_d = FINISH;
          end else if (gap_q != '0) begin
            state_d = GAP;
            gcnt_d  = gap_q;
          end
        end
      end
      GAP: begin
        // Leaving at a count of 1 gives exactly gap idle cycles.
        if (gcnt_q == GAP_ONE) begin
          state_d = SEND;
        end else begin
          gcnt_d = gcnt_q - GAP_ONE;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q  <= IDLE;
      len_q    <= '0;
      gap_q    <= '0;
      gcnt_q   <= '0;
      ws_q     <= '0;
      tvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      gap_q    <= gap_d;
      gcnt_q   <= gcnt_d;
      ws_q     <= ws_d;
      tvalid_q <= (state_d == SEND);
      busy_q   <= (state_d != IDLE);
      done_q   <= (state_d == FINISH);
    end
  end

  axis_burst_datagen #(
    .AXI_DATA_WIDTH(AXI_DATA_WIDTH)
  ) u_datagen (
    .clk_i     (aclk),
    .rst_i     (areset),
    .load_i    (dg_load),
    .advance_i (dg_adv),
    .mode_i    (mode),
    .seed_i    (seed),
    .tdata_o   (m_axis_tdata)
  );

  assign m_axis_tvalid = tvalid_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign words_sent    = ws_q;

endmodule

// File: tb/tb_axis_burst_gen.sv
// Self-checking bench for axis_burst_gen: a transaction-level model predicts the
// beat sequence, gaps, busy/done timing and word count, checked every cycle.
module tb_axis_burst_gen;

  localparam int DW  = 64;
  localparam int BLW = 16;
  localparam int GW  = 8;

  // ---------------- clock / reset / DUT ----------------
  logic           aclk = 1'b0;
  logic           areset = 1'b1;
  logic           start = 1'b0;
  logic           mode = 1'b0;
  logic [31:0]    seed = '0;
  logic [BLW-1:0] burst_len = '0;
  logic [GW-1:0]  gap = '0;
  logic           busy, done;
  logic [BLW-1:0] words_sent;
  logic [DW-1:0]  m_axis_tdata;
  logic           m_axis_tvalid;
  logic           m_axis_tready = 1'b0;

  always #5 aclk = ~aclk;

  axis_burst_gen #(
    .AXI_DATA_WIDTH (DW),
    .BURST_LEN_WIDTH(BLW),
    .GAP_WIDTH      (GW)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .start         (start),
    .mode          (mode),
    .seed          (seed),
    .burst_len     (burst_len),
    .gap           (gap),
    .busy          (busy),
    .done          (done),
    .words_sent    (words_sent),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready)
  );

  int n_cmp = 0;
  int n_err = 0;
  int rdy_mode = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] m_next(bit lfsr, logic [31:0] s);
    logic fb;
    if (!lfsr) return s + 32'd1;
    fb = s[31] ^ s[21] ^ s[1] ^ s[0];
    return (s << 1) | {31'd0, fb};
  endfunction

  function automatic logic [DW-1:0] rep(logic [31:0] v);
    return {(DW/32){v}};
  endfunction

  logic [31:0]   exp_q[$];
  logic [31:0]   got_q[$];
  bit            mon_en = 0;
  bit            m_busy = 0;
  bit            m_done = 0;
  bit            gap_pend = 0;
  bit            prev_stall = 0;
  int            beats = 0;
  int            exp_len = 0;
  int            exp_idle = 0;
  int            cfg_gap = 0;
  int            idle = 0;
  logic [DW-1:0] prev_data = '0;

  // One compare process: checks this cycle, then advances the model to the next.
  always @(negedge aclk) begin
    bit          next_done;
    logic [31:0] v;
    logic [31:0] s;
    if (mon_en) begin
      next_done = 0;
      chk("busy", 64'(busy), 64'(m_busy));
      chk("done", 64'(done), 64'(m_done));
      chk("words_sent", 64'(words_sent), 64'(beats));
      if (!m_busy || m_done) chk("tvalid_low", 64'(m_axis_tvalid), 64'd0);
      if (prev_stall) begin
        chk("stall_valid", 64'(m_axis_tvalid), 64'd1);
        chk("stall_data", 64'(m_axis_tdata), 64'(prev_data));
      end
      prev_stall = 0;
      if (m_axis_tvalid === 1'b1) begin
        if (gap_pend) begin
          chk("idle_cycles", 64'(idle), 64'(exp_idle));
          gap_pend = 0;
        end
        if (m_axis_tready) begin
          if (exp_q.size() == 0) begin
            chk("extra_beat", 64'd1, 64'd0);
          end else begin
            v = exp_q.pop_front();
            chk("tdata", 64'(m_axis_tdata), 64'(rep(v)));
          end
          got_q.push_back(m_axis_tdata[31:0]);
          beats++;
          if (beats == exp_len) begin
            next_done = 1;
          end else begin
            gap_pend = 1;
            idle     = 0;
            exp_idle = cfg_gap;
          end
        end else begin
          prev_stall = 1;
          prev_data  = m_axis_tdata;
        end
      end else if (gap_pend) begin
        idle++;
        if (idle > exp_idle) begin
          chk("idle_overrun", 64'(idle), 64'(exp_idle));
          gap_pend = 0;
        end
      end
      if (areset) begin
        m_busy = 0; m_done = 0; beats = 0; gap_pend = 0; prev_stall = 0;
        exp_q.delete();
      end else if (m_done) begin
        m_busy = 0; m_done = 0;
      end else if (next_done) begin
        m_done = 1;
      end else if (!m_busy && start) begin
        m_busy  = 1;
        beats   = 0;
        exp_len = int'(burst_len);
        cfg_gap = int'(gap);
        exp_q.delete();
        s = (mode && seed == 32'd0) ? 32'd1 : seed;
        for (int i = 0; i < exp_len; i++) begin
          exp_q.push_back(s);
          s = m_next(mode, s);
        end
        if (exp_len == 0) begin
          m_done = 1;
        end else begin
          gap_pend = 1; idle = 0; exp_idle = 0;
        end
      end
    end
  end

  // ---------------- tready driver ----------------
  initial begin
    forever begin
      @(posedge aclk);
      #1;
      case (rdy_mode)
        0: m_axis_tready = 1'b1;
        1: m_axis_tready = ~m_axis_tready;
        2: m_axis_tready = 1'($urandom_range(0, 1));
        default: m_axis_tready = 1'b0;
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(bit m, logic [31:0] sd, int len, int g);
    @(posedge aclk);
    #1;
    mode = m; seed = sd; burst_len = BLW'(len); gap = GW'(g); start = 1'b1;
    got_q.delete();
    @(posedge aclk);
    #1;
    start = 1'b0;
    mode = 1'($urandom_range(0, 1));
    seed = $urandom;
    burst_len = BLW'($urandom_range(0, 50));
    gap = GW'($urandom_range(0, 9));
  endtask

  task automatic pulse_start();
    @(posedge aclk);
    #1;
    start = 1'b1; seed = 32'hDEAD0000; burst_len = BLW'(2); gap = '0;
    @(posedge aclk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(string name, int limit);
    int k;
    k = 0;
    do begin
      @(negedge aclk);
      k++;
    end while (done !== 1'b1 && k < limit);
    if (done !== 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: done not seen within %0d cycles", name, limit);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_ws", 64'(words_sent), 64'd0);
    chk("rst_tdata", 64'(m_axis_tdata), 64'd0);
    mon_en = 1;
    @(posedge aclk);
    #1;
    areset = 1'b0;

    // counter, back-to-back, then a start during the done cycle
    rdy_mode = 0;
    do_start(0, 32'h10, 4, 0);
    wait_done("t1", 50);
    chk("t1_ws", 64'(words_sent), 64'd4);
    chk("t1_n", 64'(got_q.size()), 64'd4);
    chk("t1_d0", 64'(got_q[0]), 64'h10);
    chk("t1_d1", 64'(got_q[1]), 64'h11);
    chk("t1_d2", 64'(got_q[2]), 64'h12);
    chk("t1_d3", 64'(got_q[3]), 64'h13);
    #1;
    start = 1'b1;
    @(posedge aclk);
    #1;
    start = 1'b0;
    @(negedge aclk);
    chk("finish_start_ignored", 64'(busy), 64'd0);

    // gap of two idle cycles
    do_start(0, 32'h100, 4, 2);
    wait_done("t2", 100);
    chk("t2_n", 64'(got_q.size()), 64'd4);
    chk("t2_d3", 64'(got_q[3]), 64'h103);

    // toggling and random tready
    rdy_mode = 1;
    do_start(0, 32'hABCD0000, 8, 1);
    wait_done("t3a", 200);
    chk("t3a_n", 64'(got_q.size()), 64'd8);
    rdy_mode = 2;
    do_start(1, 32'h12345678, 20, 0);
    wait_done("t3b", 500);
    chk("t3b_n", 64'(got_q.size()), 64'd20);

    // tready held low: the block waits with the first beat pending
    rdy_mode = 3;
    do_start(0, 32'h5, 3, 0);
    repeat (20) @(negedge aclk);
    chk("stall_busy", 64'(busy), 64'd1);
    chk("stall_ws", 64'(words_sent), 64'd0);
    chk("stall_tdata", 64'(m_axis_tdata), 64'(rep(32'h5)));
    rdy_mode = 0;
    wait_done("t3c", 50);
    chk("t3c_n", 64'(got_q.size()), 64'd3);

    // LFSR with zero seed, long burst
    do_start(1, 32'h0, 1000, 0);
    wait_done("t4", 1100);
    chk("t4_n", 64'(got_q.size()), 64'd1000);
    chk("t4_d0", 64'(got_q[0]), 64'h1);
    chk("t4_d1", 64'(got_q[1]), 64'h3);
    chk("t4_d2", 64'(got_q[2]), 64'h6);
    chk("t4_d3", 64'(got_q[3]), 64'hD);

    // zero-length burst and counter wrap
    do_start(0, 32'h77, 0, 5);
    wait_done("t5a", 10);
    chk("t5a_n", 64'(got_q.size()), 64'd0);
    do_start(0, 32'hFFFFFFFE, 3, 0);
    wait_done("t5b", 20);
    chk("t5b_d0", 64'(got_q[0]), 64'hFFFFFFFE);
    chk("t5b_d1", 64'(got_q[1]), 64'hFFFFFFFF);
    chk("t5b_d2", 64'(got_q[2]), 64'h0);

    // start while busy is ignored
    do_start(0, 32'h200, 6, 1);
    pulse_start();
    wait_done("t6a", 100);
    chk("t6a_n", 64'(got_q.size()), 64'd6);

    // reset mid-burst, then a clean burst
    do_start(0, 32'h300, 10, 0);
    repeat (3) @(negedge aclk);
    @(posedge aclk);
    #1;
    areset = 1'b1;
    @(posedge aclk);
    #1;
    areset = 1'b0;
    @(negedge aclk);
    chk("mid_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_ws", 64'(words_sent), 64'd0);
    do_start(0, 32'h400, 5, 0);
    wait_done("t6b", 50);
    chk("t6b_n", 64'(got_q.size()), 64'd5);
    chk("t6b_d0", 64'(got_q[0]), 64'h400);
    repeat (3) @(negedge aclk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
